pulse_period_checker: RTL and testbench

PULSE_PERIOD_CHECKER -- requirements
Module: pulse_period_checker

---
 rtl/pulse_period_checker.sv | 120 ++++++++++++
 tb/tb_pulse_period_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pulse_period_checker : measures pulse intervals and locks onto period N     |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module pulse_period_checker #(
   parameter int N          = 5,
   parameter int LOCK_COUNT = 3,
   parameter int MAX_PERIOD = 255,
   localparam int W         = $clog2(MAX_PERIOD + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         pulse,
   output logic         locked,
   output logic [W-1:0] period,
   output logic         period_valid,
   output logic         err_early,
   output logic         err_late,
   output logic [7:0]   err_cnt
);

   localparam int           MW      = $clog2(LOCK_COUNT + 1);
   localparam logic [W-1:0] CNT_N   = W'(N);
   localparam logic [W-1:0] CNT_MAX = W'(MAX_PERIOD);
   localparam logic [MW-1:0] M_LAST = MW'(LOCK_COUNT - 1);
   localparam logic [MW-1:0] M_FULL = MW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t          state;
   logic [W-1:0]    cnt;
   logic [MW-1:0]   m;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         m            <= '0;
         period       <= '0;
         locked       <= 1'b0;
         period_valid <= 1'b0;
         err_early    <= 1'b0;
         err_late     <= 1'b0;
         err_cnt      <= '0;
      end else begin
         period_valid <= 1'b0;
         err_early    <= 1'b0;
         err_late     <= 1'b0;

         // cnt holds the interval measured at this edge if a pulse is present
         if (pulse)
            cnt <= W'(1);
         else if (cnt != CNT_MAX)
            cnt <= cnt + W'(1);

         case (state)
            ST_IDLE: begin
               if (pulse) begin
                  state <= ST_TRACK;
                  m     <= '0;
               end
            end

            ST_TRACK: begin
               if (pulse) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  if (cnt == CNT_N) begin
                     if (m == M_LAST) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                        m      <= M_FULL;
                     end else begin
                        m <= m + MW'(1);
                     end
                  end else begin
                     m <= '0;
                  end
               end
            end

            ST_LOCKED: begin
               if (pulse) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  // locked pulses can only arrive at or before N; late ones exit first
                  if (cnt != CNT_N) begin
                     err_early <= 1'b1;
                     state     <= ST_TRACK;
                     locked    <= 1'b0;
                     m         <= '0;
                     if (err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                  end
               end else if (cnt == CNT_N) begin
                  err_late <= 1'b1;
                  state    <= ST_IDLE;
                  locked   <= 1'b0;
                  m        <= '0;
                  if (err_cnt != 8'hFF)
                     err_cnt <= err_cnt + 8'd1;
               end
            end

            default: begin
               state  <= ST_IDLE;
               locked <= 1'b0;
               m      <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_pulse_period_checker : scoreboard bench for pulse_period_checker rev 1.0 |
// +-----------------------------------------------------------------------------+
module tb_pulse_period_checker;

   localparam int N          = 5;
   localparam int LOCK_COUNT = 3;
   localparam int MAX_PERIOD = 255;
   localparam int W          = $clog2(MAX_PERIOD + 1);

   logic         clk;
   logic         reset;
   logic         pulse;
   logic         locked;
   logic [W-1:0] period;
   logic         period_valid;
   logic         err_early;
   logic         err_late;
   logic [7:0]   err_cnt;

   pulse_period_checker #(
      .N          (N),
      .LOCK_COUNT (LOCK_COUNT),
      .MAX_PERIOD (MAX_PERIOD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pulse        (pulse),
      .locked       (locked),
      .period       (period),
      .period_valid (period_valid),
      .err_early    (err_early),
      .err_late     (err_late),
      .err_cnt      (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int lk;
      int per;
      int pv;
      int ee;
      int el;
      int ec;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   // reference model, expressed as edge index of the last pulse
   int m_state  = 0;   // 0 idle, 1 track, 2 locked
   int m_match  = 0;
   int m_last   = 0;
   int m_edge   = 0;
   int m_period = 0;
   int m_errcnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input logic p, input logic r);
      exp_t e;
      int   iv;
      @(negedge clk);
      pulse = p;
      reset = r;
      m_edge++;
      iv = m_edge - m_last;
      if (iv > MAX_PERIOD) iv = MAX_PERIOD;
      e.pv = 0;
      e.ee = 0;
      e.el = 0;
      if (r) begin
         m_state  = 0;
         m_match  = 0;
         m_period = 0;
         m_errcnt = 0;
      end else begin
         case (m_state)
            0: if (p) begin
                  m_state = 1;
                  m_match = 0;
               end
            1: if (p) begin
                  m_period = iv;
                  e.pv     = 1;
                  if (iv == N) begin
                     m_match++;
                     if (m_match == LOCK_COUNT) m_state = 2;
                  end else begin
                     m_match = 0;
                  end
               end
            default: begin
               if (p) begin
                  m_period = iv;
                  e.pv     = 1;
                  if (iv != N) begin
                     e.ee    = 1;
                     m_state = 1;
                     m_match = 0;
                  end
               end else if (iv == N) begin
                  e.el    = 1;
                  m_state = 0;
                  m_match = 0;
               end
            end
         endcase
         if (p) m_last = m_edge;
         if ((e.ee != 0 || e.el != 0) && m_errcnt < 255) m_errcnt++;
      end
      e.lk  = (m_state == 2) ? 1 : 0;
      e.per = m_period;
      e.ec  = m_errcnt;
      sb.push_back(e);

      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("locked",       {31'd0, locked},       e.lk);
         chk("period",       {24'd0, period},       e.per);
         chk("period_valid", {31'd0, period_valid}, e.pv);
         chk("err_early",    {31'd0, err_early},    e.ee);
         chk("err_late",     {31'd0, err_late},     e.el);
         chk("err_cnt",      {24'd0, err_cnt},      e.ec);
         chk("err_both",     {31'd0, err_early & err_late}, 32'd0);
      end
   endtask

   task automatic send(input int gap);
      step(1'b1, 1'b0);
      repeat (gap - 1) step(1'b0, 1'b0);
   endtask

   initial begin
      pulse = 1'b0;
      reset = 1'b1;

      // reset, including a pulse that must be ignored
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk("rst_locked",  {31'd0, locked}, 32'd0);
      chk("rst_period",  {24'd0, period}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

      // steady train at period N locks after the fourth pulse
      repeat (3) send(5);
      step(1'b1, 1'b0);
      chk("lock_after_p4", {31'd0, locked}, 32'd1);
      chk("lock_period",   {24'd0, period}, 32'd5);
      repeat (4) step(1'b0, 1'b0);
      repeat (2) send(5);

      // one 7-cycle gap: late error, then relock
      send(7);
      chk("late_cnt", {24'd0, err_cnt}, 32'd1);
      repeat (4) send(5);
      chk("relock_late", {31'd0, locked}, 32'd1);

      // early pulse at 3 cycles
      send(3);
      step(1'b1, 1'b0);
      chk("early_period", {24'd0, period},       32'd3);
      chk("early_pv",     {31'd0, period_valid}, 32'd1);
      chk("early_flag",   {31'd0, err_early},    32'd1);
      chk("early_unlock", {31'd0, locked},       32'd0);
      repeat (4) step(1'b0, 1'b0);
      repeat (2) send(5);
      step(1'b1, 1'b0);
      chk("relock_early", {31'd0, locked},  32'd1);
      chk("early_cnt",    {24'd0, err_cnt}, 32'd2);
      repeat (4) step(1'b0, 1'b0);

      // single-cycle reset while locked
      step(1'b0, 1'b1);
      chk("mid_rst_locked",  {31'd0, locked},  32'd0);
      chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      step(1'b1, 1'b0);
      chk("post_rst_ref_pv", {31'd0, period_valid}, 32'd0);

      // long silence saturates the interval
      repeat (300) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("sat_period", {24'd0, period},       32'd255);
      chk("sat_pv",     {31'd0, period_valid}, 32'd1);
      chk("sat_locked", {31'd0, locked},       32'd0);

      // pulse held high measures 1 every edge
      repeat (12) step(1'b1, 1'b0);
      chk("held_period", {24'd0, period}, 32'd1);
      chk("held_locked", {31'd0, locked}, 32'd0);
      step(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
